// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier datapath and its controller.
package mul_pkg;

  localparam int WIDTH_DEF = 16;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  // Strobe bundle exchanged between the multiplier controller and datapath.
  typedef struct packed {
    logic lda;
    logic ldb;
    logic ldp;
    logic clrp;
    logic decb;
  } mul_ctrl_t;

endpackage

// File: rtl/mul_down_cntr.sv
// Multiplier B register: loadable down-counter that saturates at zero and flags zero.
module mul_down_cntr
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] data_in,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else if (dec && count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier datapath: A register, B down-counter and P accumulator.
// Optional build macro MUL_DP_ZERO_A_EN also terminates early when A is zero.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         lda,
  input  logic                         ldb,
  input  logic                         clrp,
  input  logic                         ldp,
  input  logic                         decb,
  output logic                         eqz,
  output logic [prod_width(WIDTH)-1:0] p_out
);

  localparam int PW = prod_width(WIDTH);

  mul_ctrl_t        ctrl;
  logic [WIDTH-1:0] a_q;
  logic [PW-1:0]    p_q;
  logic             b_zero;
  logic             done;

  assign ctrl = '{lda: lda, ldb: ldb, ldp: ldp, clrp: clrp, decb: decb};

`ifdef MUL_DP_ZERO_A_EN
  assign done = b_zero || (a_q == '0);
`else
  assign done = b_zero;
`endif

  // Both ldp and decb are qualified by the pre-edge status, so P ends at exactly A*B.
  mul_down_cntr #(.WIDTH(WIDTH)) u_b_cntr (
    .clk     (clk),
    .rst     (rst),
    .load    (ctrl.ldb),
    .dec     (ctrl.decb && !done),
    .data_in (data_in),
    .zero    (b_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
    end else if (ctrl.lda) begin
      a_q <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else if (ctrl.clrp) begin
      p_q <= '0;
    end else if (ctrl.ldp && !done) begin
      p_q <= p_q + {{WIDTH{1'b0}}, a_q};
    end
  end

  assign eqz   = done;
  assign p_out = p_q;

endmodule
